// File: rtl/ir_queue.sv
// ============================================================================
// Module   : ir_queue
// Purpose  : DEPTH-entry instruction FIFO with head decode (fields, immediate).
//            Optional macro IR_BYPASS_EN: empty-queue same-cycle bypass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ir_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  inst_in,
    input  logic                         inst_valid,
    output logic                         inst_ready,
    input  logic                         advance,
    input  logic                         flush,
    output logic                         ir_valid,
    output logic [31:0]                  inst_out,
    output logic [6:0]                   opcode,
    output logic [4:0]                   dest,
    output logic [2:0]                   funct3,
    output logic [4:0]                   reg1,
    output logic [4:0]                   reg2,
    output logic [6:0]                   funct7,
    output logic [XLEN-1:0]              imm,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int          c_PW  = $clog2(DEPTH);
    localparam int          c_CW  = $clog2(DEPTH + 1);
    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic [31:0]     r_mem [DEPTH];
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;

    logic            w_empty;
    logic            w_full;
    logic            w_bypass;
    logic            w_push;
    logic            w_pop;
    logic [31:0]     w_imm32;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_CW'(DEPTH));

`ifdef IR_BYPASS_EN
    assign w_bypass = w_empty && inst_valid && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed instruction consumed in the same cycle is never written.
    assign w_push = inst_valid && !w_full && !flush && !(w_bypass && advance);
    assign w_pop  = advance && !w_empty && !flush;

    assign inst_ready = !w_full;
    assign ir_valid   = !w_empty || w_bypass;
    assign count      = r_count;

    always_comb begin
        inst_out = c_NOP;
        if (!w_empty) begin
            inst_out = r_mem[r_rptr];
        end else if (w_bypass) begin
            inst_out = inst_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= inst_in;
        end
    end

    assign opcode = inst_out[6:0];
    assign dest   = inst_out[11:7];
    assign funct3 = inst_out[14:12];
    assign reg1   = inst_out[19:15];
    assign reg2   = inst_out[24:20];
    assign funct7 = inst_out[31:25];

    always_comb begin
        w_imm32 = '0;
        unique case (inst_out[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
                w_imm32 = {{20{inst_out[31]}}, inst_out[31:20]};
            7'b0100011:
                w_imm32 = {{20{inst_out[31]}}, inst_out[31:25], inst_out[11:7]};
            7'b1100011:
                w_imm32 = {{19{inst_out[31]}}, inst_out[31], inst_out[7],
                           inst_out[30:25], inst_out[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                w_imm32 = {inst_out[31:12], 12'b0};
            7'b1101111:
                w_imm32 = {{11{inst_out[31]}}, inst_out[31], inst_out[19:12],
                           inst_out[20], inst_out[30:21], 1'b0};
            default:
                w_imm32 = '0;
        endcase
    end

    // XLEN >= 32, so at least one replicated sign bit always exists.
    assign imm = {{(XLEN-31){w_imm32[31]}}, w_imm32[30:0]};

endmodule

`default_nettype wire

// File: tb/tb_ir_queue.sv
// ============================================================================
// Module   : tb_ir_queue
// Purpose  : Directed self-checking bench for ir_queue (XLEN=32, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ir_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst_in = '0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic        advance = 1'b0;
    logic        flush = 1'b0;
    logic        ir_valid;
    logic [31:0] inst_out;
    logic [6:0]  opcode;
    logic [4:0]  dest;
    logic [2:0]  funct3;
    logic [4:0]  reg1;
    logic [4:0]  reg2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    ir_queue #(.XLEN(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .inst_in(inst_in), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .advance(advance), .flush(flush),
        .ir_valid(ir_valid), .inst_out(inst_out), .opcode(opcode), .dest(dest),
        .funct3(funct3), .reg1(reg1), .reg2(reg2), .funct7(funct7), .imm(imm),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        inst_in = w; inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
    endtask

    task automatic pop();
        advance = 1'b1;
        tick();
        advance = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", count); end
        n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL rst_ir_valid: got %b want 0", ir_valid); end
        n_cmp++; if (inst_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", inst_ready); end
        n_cmp++; if (inst_out !== 32'h00000013) begin n_err++; $display("FAIL rst_inst_out: got %h want 00000013", inst_out); end
        n_cmp++; if (opcode !== 7'b0010011 || dest !== 5'd0 || reg1 !== 5'd0 || imm !== 32'd0)
            begin n_err++; $display("FAIL rst_fields: got op=%b rd=%0d rs1=%0d imm=%h want op=0010011 0 0 0", opcode, dest, reg1, imm); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_push_decode();
        inst_in = 32'h04202023; inst_valid = 1'b1;
        #1;
`ifdef IR_BYPASS_EN
        n_cmp++; if (ir_valid !== 1'b1 || inst_out !== 32'h04202023) begin n_err++; $display("FAIL bypass_same_cycle: got v=%b %h want 1 04202023", ir_valid, inst_out); end
`else
        n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL latency_same_cycle: got v=%b want 0", ir_valid); end
`endif
        tick();
        inst_valid = 1'b0;
        n_cmp++; if (ir_valid !== 1'b1 || inst_out !== 32'h04202023) begin n_err++; $display("FAIL push1_head: got v=%b %h want 1 04202023", ir_valid, inst_out); end
        n_cmp++; if (opcode !== 7'b0100011 || reg1 !== 5'd0 || reg2 !== 5'd2 || dest !== 5'd0 || funct3 !== 3'd2 || funct7 !== 7'd2)
            begin n_err++; $display("FAIL push1_fields: got op=%b rs1=%0d rs2=%0d rd=%0d f3=%0d f7=%0d", opcode, reg1, reg2, dest, funct3, funct7); end
        n_cmp++; if (imm !== 32'd64) begin n_err++; $display("FAIL push1_imm: got %h want 00000040", imm); end
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL push1_count: got %0d want 1", count); end
        push(32'h00110113);
        n_cmp++; if (count !== 3'd2 || inst_out !== 32'h04202023) begin n_err++; $display("FAIL push2_state: got cnt=%0d %h want 2 04202023", count, inst_out); end
        pop();
        n_cmp++; if (inst_out !== 32'h00110113 || reg1 !== 5'd2 || dest !== 5'd2 || funct3 !== 3'd0 || imm !== 32'd1)
            begin n_err++; $display("FAIL pop1_head: got %h rs1=%0d rd=%0d f3=%0d imm=%h want 00110113 2 2 0 1", inst_out, reg1, dest, funct3, imm); end
        pop();
        n_cmp++; if (ir_valid !== 1'b0 || inst_out !== 32'h00000013 || count !== 3'd0)
            begin n_err++; $display("FAIL pop_to_empty: got v=%b %h cnt=%0d want 0 00000013 0", ir_valid, inst_out, count); end
        pop();
        n_cmp++; if (count !== 3'd0 || ir_valid !== 1'b0) begin n_err++; $display("FAIL pop_when_empty: got cnt=%0d v=%b want 0 0", count, ir_valid); end
    endtask

    task automatic test_full_wrap();
        logic [31:0] words [6];
        words = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004, 32'hA0000005, 32'hA0000006};
        for (int i = 0; i < 4; i++) push(words[i]);
        n_cmp++; if (count !== 3'd4 || inst_ready !== 1'b0) begin n_err++; $display("FAIL full_state: got cnt=%0d rdy=%b want 4 0", count, inst_ready); end
        push(words[4]);
        n_cmp++; if (count !== 3'd4 || inst_out !== words[0]) begin n_err++; $display("FAIL full_drop: got cnt=%0d %h want 4 %h", count, inst_out, words[0]); end
        // Push while full, with a pop in the same cycle: push still dropped.
        inst_in = words[5]; inst_valid = 1'b1; advance = 1'b1;
        tick();
        inst_valid = 1'b0; advance = 1'b0;
        n_cmp++; if (count !== 3'd3 || inst_ready !== 1'b1) begin n_err++; $display("FAIL full_pushpop: got cnt=%0d rdy=%b want 3 1", count, inst_ready); end
        for (int i = 1; i < 4; i++) begin
            n_cmp++; if (inst_out !== words[i] || ir_valid !== 1'b1) begin n_err++; $display("FAIL wrap_order%0d: got %h want %h", i, inst_out, words[i]); end
            pop();
        end
        n_cmp++; if (ir_valid !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL wrap_empty: got v=%b cnt=%0d want 0 0", ir_valid, count); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [5];
        words = '{32'hB0000001, 32'hB0000002, 32'hB0000003, 32'hB0000004, 32'hB0000005};
        push(words[0]);
        push(words[1]);
        for (int i = 0; i < 3; i++) begin
            inst_in = words[i+2]; inst_valid = 1'b1; advance = 1'b1;
            #1;
            n_cmp++; if (inst_out !== words[i]) begin n_err++; $display("FAIL b2b_head%0d: got %h want %h", i, inst_out, words[i]); end
            tick();
            n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL b2b_count%0d: got %0d want 2", i, count); end
        end
        inst_valid = 1'b0; advance = 1'b0;
        for (int i = 3; i < 5; i++) begin
            n_cmp++; if (inst_out !== words[i]) begin n_err++; $display("FAIL b2b_tail%0d: got %h want %h", i, inst_out, words[i]); end
            pop();
        end
    endtask

    task automatic test_imm_flush();
        logic [31:0] w [3];
        logic [31:0] e [3];
        w = '{32'h12345037, 32'hFFDFF0EF, 32'hFFFFFFFF};
        e = '{32'h12345000, 32'hFFFFFFFC, 32'h00000000};
        for (int i = 0; i < 3; i++) begin
            push(w[i]);
            n_cmp++; if (imm !== e[i]) begin n_err++; $display("FAIL imm_fmt%0d: got %h want %h", i, imm, e[i]); end
            pop();
        end
        push(32'hFE000EE3);
        n_cmp++; if (imm !== 32'hFFFFFFFC) begin n_err++; $display("FAIL imm_btype: got %h want fffffffc", imm); end
        push(32'h00110113);
        inst_in = 32'hC0000001; inst_valid = 1'b1; advance = 1'b1; flush = 1'b1;
        tick();
        inst_valid = 1'b0; advance = 1'b0; flush = 1'b0;
        n_cmp++; if (count !== 3'd0 || ir_valid !== 1'b0 || inst_out !== 32'h00000013 || inst_ready !== 1'b1)
            begin n_err++; $display("FAIL flush_state: got cnt=%0d v=%b %h rdy=%b want 0 0 00000013 1", count, ir_valid, inst_out, inst_ready); end
        push(32'hC0000002);
        n_cmp++; if (inst_out !== 32'hC0000002 || count !== 3'd1) begin n_err++; $display("FAIL post_flush: got %h cnt=%0d want c0000002 1", inst_out, count); end
        pop();
    endtask

    task automatic test_async_reset();
        push(32'hD0000001);
        push(32'hD0000002);
        push(32'hD0000003);
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL pre_rst_count: got %0d want 3", count); end
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0 || ir_valid !== 1'b0 || inst_ready !== 1'b1 || inst_out !== 32'h00000013)
            begin n_err++; $display("FAIL async_rst: got cnt=%0d v=%b rdy=%b %h want 0 0 1 00000013", count, ir_valid, inst_ready, inst_out); end
        #1 rst = 1'b1;
        push(32'hD0000004);
        n_cmp++; if (inst_out !== 32'hD0000004 || count !== 3'd1) begin n_err++; $display("FAIL post_rst_push: got %h cnt=%0d want d0000004 1", inst_out, count); end
    endtask

    initial begin
        test_reset();
        test_push_decode();
        test_full_wrap();
        test_back_to_back();
        test_imm_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
